ifu_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of the decode stage.
- Holds the architectural PC and issues one read per instruction on an AXI4-Lite-style read channel.
- Presents {instruction, pc} to decode with a valid/ready handshake.
- Waits for decode's pc_write_enable / pc_next before fetching the next instruction: single outstanding fetch, no prediction.

---
 rtl/ifu_fetch.sv | 116 +++++++++++
 tb/tb_ifu_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
//------------------------------------------------------------------------------
// Module  : ifu_fetch
// Brief   : Single-outstanding instruction fetch stage feeding decode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h80000000,
  parameter logic [31:0] TRAP_INSN = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        ifu_send_valid,
  input  logic        ifu_send_ready,
  output logic        fetch_error,
  output logic [31:0] fetch_count,
  output logic [31:0] mem_wait_count
);

  typedef enum logic [1:0] {
    S_AR     = 2'd0,
    S_R      = 2'd1,
    S_SEND   = 2'd2,
    S_WAITPC = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic        r_fetch_error;
  logic [31:0] r_fetch_count;
  logic [31:0] r_mem_wait_count;
  logic        w_misaligned;

  assign w_misaligned = (pc_next[1:0] != 2'b00);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_AR:     if (arready) w_state_next = S_R;
      S_R:      if (rvalid) w_state_next = S_SEND;
      S_SEND:   if (ifu_send_ready) w_state_next = S_WAITPC;
      S_WAITPC: if (pc_write_enable) w_state_next = w_misaligned ? S_SEND : S_AR;
      default:  w_state_next = S_AR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_AR;
      r_pc             <= RESET_PC;
      r_instruction    <= 32'h0;
      r_fetch_error    <= 1'b0;
      r_fetch_count    <= 32'h0;
      r_mem_wait_count <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_AR) || (r_state == S_R))
        r_mem_wait_count <= r_mem_wait_count + 32'd1;
      case (r_state)
        S_R: begin
          if (rvalid) begin
            // Any non-OKAY response is replaced by the trap so decode halts cleanly
            if (rresp != 2'b00) begin
              r_instruction <= TRAP_INSN;
              r_fetch_error <= 1'b1;
            end else begin
              r_instruction <= rdata;
              r_fetch_error <= 1'b0;
            end
          end
        end
        S_SEND: begin
          if (ifu_send_ready)
            r_fetch_count <= r_fetch_count + 32'd1;
        end
        S_WAITPC: begin
          if (pc_write_enable) begin
            r_pc <= pc_next;
            if (w_misaligned) begin
              r_instruction <= TRAP_INSN;
              r_fetch_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign arvalid        = (r_state == S_AR);
  assign araddr         = r_pc;
  assign rready         = (r_state == S_R);
  assign ifu_send_valid = (r_state == S_SEND);
  assign instruction    = r_instruction;
  assign pc             = r_pc;
  assign fetch_error    = r_fetch_error;
  assign fetch_count    = r_fetch_count;
  assign mem_wait_count = r_mem_wait_count;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
//------------------------------------------------------------------------------
// Module  : tb_ifu_fetch
// Brief   : Directed bench for ifu_fetch with a queue-based handoff scoreboard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifu_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h80000000;
  localparam logic [31:0] C_TRAP     = 32'h00100073;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_write_enable;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        ifu_send_valid;
  logic        ifu_send_ready;
  logic        fetch_error;
  logic [31:0] fetch_count;
  logic [31:0] mem_wait_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected handoff: {instruction, pc, fetch_error}
  logic [64:0] exp_q[$];

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_next        (pc_next),
    .pc_write_enable(pc_write_enable),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .instruction    (instruction),
    .pc             (pc),
    .ifu_send_valid (ifu_send_valid),
    .ifu_send_ready (ifu_send_ready),
    .fetch_error    (fetch_error),
    .fetch_count    (fetch_count),
    .mem_wait_count (mem_wait_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && ifu_send_valid && ifu_send_ready) begin
      logic [64:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got insn=%h pc=%h err=%b with empty queue",
                 instruction, pc, fetch_error);
      end else begin
        e = exp_q.pop_front();
        if ({instruction, pc, fetch_error} !== e) begin
          n_fail++;
          $display("FAIL sb_handoff: got insn=%h pc=%h err=%b expected insn=%h pc=%h err=%b",
                   instruction, pc, fetch_error, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; pc_next = 32'h0; pc_write_enable = 1'b0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    ifu_send_ready = 1'b0;

    // Reset state
    step();
    chk("rst_pc", pc, C_RESET_PC);
    chk("rst_insn", instruction, 32'h0);
    chk("rst_err", {31'h0, fetch_error}, 32'h0);
    chk("rst_fcnt", fetch_count, 32'h0);
    chk("rst_mwcnt", mem_wait_count, 32'h0);
    chk("rst_arvalid", {31'h0, arvalid}, 32'h1);
    chk("rst_valid", {31'h0, ifu_send_valid}, 32'h0);

    // Zero-wait memory; rvalid high during S_AR must not be consumed early
    rst = 1'b1; arready = 1'b1; rvalid = 1'b1; rdata = 32'h00000413; ifu_send_ready = 1'b1;
    exp_q.push_back({32'h00000413, C_RESET_PC, 1'b0});
    chk("zw_araddr_c0", araddr, C_RESET_PC);
    step();
    chk("zw_rready_c1", {31'h0, rready}, 32'h1);
    step();
    arready = 1'b0; rvalid = 1'b0;
    chk("zw_valid_c2", {31'h0, ifu_send_valid}, 32'h1);
    chk("zw_insn_c2", instruction, 32'h00000413);
    chk("zw_pc_c2", pc, C_RESET_PC);
    chk("zw_mwcnt", mem_wait_count, 32'd2);
    step();
    chk("zw_fcnt", fetch_count, 32'd1);
    chk("zw_waitpc_valid", {31'h0, ifu_send_valid}, 32'h0);

    // Redirect
    pc_write_enable = 1'b1; pc_next = 32'h80000100;
    step();
    pc_write_enable = 1'b0;
    chk("rd_arvalid", {31'h0, arvalid}, 32'h1);
    chk("rd_araddr", araddr, 32'h80000100);
    ifu_send_ready = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    // pc_write_enable pulse in S_R is ignored
    pc_write_enable = 1'b1; pc_next = 32'h12345678;
    step();
    pc_write_enable = 1'b0;
    chk("sr_pwe_pc", pc, 32'h80000100);
    chk("sr_pwe_rready", {31'h0, rready}, 32'h1);
    rvalid = 1'b1; rdata = 32'h00a00093;
    exp_q.push_back({32'h00a00093, 32'h80000100, 1'b0});
    step();
    rvalid = 1'b0; rdata = 32'hffffffff;

    // Backpressure: five stalled cycles in S_SEND
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, ifu_send_valid}, 32'h1);
      chk("bp_insn", instruction, 32'h00a00093);
      chk("bp_pc", pc, 32'h80000100);
      chk("bp_fcnt", fetch_count, 32'd1);
      step();
    end
    // Ready and pc_write_enable together in S_SEND: the redirect is dropped
    ifu_send_ready = 1'b1; pc_write_enable = 1'b1; pc_next = 32'h80000200;
    step();
    pc_write_enable = 1'b0; ifu_send_ready = 1'b0;
    chk("bp_fcnt_after", fetch_count, 32'd2);
    chk("send_pwe_pc", pc, 32'h80000100);
    step();
    chk("waitpc_hold_arvalid", {31'h0, arvalid}, 32'h0);
    chk("waitpc_hold_valid", {31'h0, ifu_send_valid}, 32'h0);

    // Bus error response
    pc_write_enable = 1'b1; pc_next = 32'h80000200;
    step();
    pc_write_enable = 1'b0;
    chk("err_araddr", araddr, 32'h80000200);
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hdeadbeef; ifu_send_ready = 1'b1;
    exp_q.push_back({C_TRAP, 32'h80000200, 1'b1});
    step();
    rvalid = 1'b0; rresp = 2'b00;
    chk("err_insn", instruction, C_TRAP);
    chk("err_flag", {31'h0, fetch_error}, 32'h1);
    step();

    // Misaligned redirect skips the bus
    ifu_send_ready = 1'b0; pc_write_enable = 1'b1; pc_next = 32'h80000102;
    exp_q.push_back({C_TRAP, 32'h80000102, 1'b1});
    step();
    pc_write_enable = 1'b0;
    chk("mis_arvalid", {31'h0, arvalid}, 32'h0);
    chk("mis_valid", {31'h0, ifu_send_valid}, 32'h1);
    chk("mis_err", {31'h0, fetch_error}, 32'h1);
    chk("mis_pc", pc, 32'h80000102);
    ifu_send_ready = 1'b1;
    step();

    // Clean fetch after a fault clears fetch_error
    pc_write_enable = 1'b1; pc_next = 32'h80000104;
    step();
    pc_write_enable = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h00000013;
    exp_q.push_back({32'h00000013, 32'h80000104, 1'b0});
    step();
    rvalid = 1'b0;
    chk("clr_err", {31'h0, fetch_error}, 32'h0);
    chk("clr_fcnt_pre", fetch_count, 32'd4);
    step();

    // Slow memory from a fresh reset
    rst = 1'b0;
    step();
    rst = 1'b1; ifu_send_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_ar_arvalid", {31'h0, arvalid}, 32'h1);
      chk("slow_ar_araddr", araddr, C_RESET_PC);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("slow_r_rready", {31'h0, rready}, 32'h1);
      chk("slow_r_araddr", araddr, C_RESET_PC);
      step();
    end
    rvalid = 1'b1; rdata = 32'h00100093; ifu_send_ready = 1'b1;
    exp_q.push_back({32'h00100093, C_RESET_PC, 1'b0});
    step();
    rvalid = 1'b0;
    chk("slow_mwcnt", mem_wait_count, 32'd9);
    step();

    // Reset while a read response is pending
    pc_write_enable = 1'b1; pc_next = 32'h80000300;
    step();
    pc_write_enable = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h11111111; rst = 1'b0;
    step();
    chk("mid_rst_pc", pc, C_RESET_PC);
    chk("mid_rst_arvalid", {31'h0, arvalid}, 32'h1);
    chk("mid_rst_valid", {31'h0, ifu_send_valid}, 32'h0);
    chk("mid_rst_fcnt", fetch_count, 32'h0);
    chk("mid_rst_mwcnt", mem_wait_count, 32'h0);
    chk("mid_rst_insn", instruction, 32'h0);
    rst = 1'b1; rvalid = 1'b0;
    step();
    step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
